wb_regfile: RTL and testbench

- Combines the pipeline writeback selector with the architectural register file: 16 GPRs, PC and CPSR.
- The writeback selector decides, from the op-class flags, whether a GPR and/or the CPSR is written and with what value.
- The register file serves combinational reads to the fetch stage (PC) and execute stage (rd/rs/rt/CPSR).
- Writes commit on the clock edge.

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/wb_regfile_wb_select.sv | 31 +++
 rtl/wb_regfile.sv | 117 +++++++++++
 tb/tb_wb_regfile.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared sizes, reset value and CPSR flag positions for the writeback /
// register-file slice.
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int REG_AW = 4;

    localparam logic [DATA_W-1:0] PC_RST = 32'h0000_0000;

    localparam int CPSR_N_BIT = 3;
    localparam int CPSR_Z_BIT = 2;
    localparam int CPSR_C_BIT = 1;
    localparam int CPSR_V_BIT = 0;

    typedef struct packed {
        logic alu;
        logic cmp;
        logic ld;
    } op_class_t;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] reg_num_t;

endpackage

// File: rtl/wb_regfile_wb_select.sv
// Writeback selector: turns the op-class flags into GPR/CPSR write enables
// and picks the GPR write data.
module wb_regfile_wb_select
    import wb_regfile_pkg::*;
(
    input  op_class_t         op_i,
    input  logic [REG_AW-1:0] rd_num_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] dmem_val_i,
    input  logic [DATA_W-1:0] cpsr_val_i,
    output logic [REG_AW-1:0] rd_num_o,
    output logic              rd_write_en_o,
    output logic [DATA_W-1:0] rd_val_o,
    output logic              cpsr_write_en_o,
    output logic [DATA_W-1:0] cpsr_val_o
);

    // Load data wins over the ALU result when both classes are flagged.
    always_comb begin
        rd_num_o        = rd_num_i;
        rd_write_en_o   = op_i.alu | op_i.ld;
        cpsr_write_en_o = op_i.cmp;
        cpsr_val_o      = cpsr_val_i;
        if (op_i.ld) begin
            rd_val_o = dmem_val_i;
        end else begin
            rd_val_o = result_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural state (16 GPRs, PC, CPSR) with write-through bypass to the
// execute-stage read ports, fed by the writeback selector.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_num_passthrough,
    input  logic [DATA_W-1:0] mem_passthrough,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] cpsr_passthrough,
    input  logic [DATA_W-1:0] dmem_val_passthrough,
    input  logic              is_alu_op_passthrough,
    input  logic              is_cmp_op_passthrough,
    input  logic              is_ld_op_passthrough,
    input  logic [DATA_W-1:0] if_pc_in,
    output logic [DATA_W-1:0] if_pc_out,
    input  logic [REG_AW-1:0] exe_rd_num,
    input  logic [REG_AW-1:0] exe_rs_num,
    input  logic [REG_AW-1:0] exe_rt_num,
    output logic [DATA_W-1:0] exe_rd_data_out,
    output logic [DATA_W-1:0] exe_rs_data_out,
    output logic [DATA_W-1:0] exe_rt_data_out,
    output logic [DATA_W-1:0] exe_cpsr_out,
    output logic [REG_AW-1:0] wb_rd_num,
    output logic              wb_rd_write_en,
    output logic [DATA_W-1:0] wb_rd_val,
    output logic              wb_cpsr_write_en,
    output logic [DATA_W-1:0] wb_cpsr_val,
    output logic [DATA_W-1:0] wb_rd_out,
    output logic [DATA_W-1:0] wb_cpsr_out
);

    op_class_t         op_s;
    logic [DATA_W-1:0] gpr_q [NREGS];
    logic [DATA_W-1:0] gpr_d [NREGS];
    logic [DATA_W-1:0] cpsr_q, cpsr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              unused_s;

    // Store data travels with the instruction but is consumed elsewhere.
    assign unused_s = ^mem_passthrough;

    assign op_s = '{alu: is_alu_op_passthrough,
                    cmp: is_cmp_op_passthrough,
                    ld:  is_ld_op_passthrough};

    wb_regfile_wb_select u_wb_select (
        .op_i            (op_s),
        .rd_num_i        (rd_num_passthrough),
        .result_i        (result),
        .dmem_val_i      (dmem_val_passthrough),
        .cpsr_val_i      (cpsr_passthrough),
        .rd_num_o        (wb_rd_num),
        .rd_write_en_o   (wb_rd_write_en),
        .rd_val_o        (wb_rd_val),
        .cpsr_write_en_o (wb_cpsr_write_en),
        .cpsr_val_o      (wb_cpsr_val)
    );

    // Next-state for all architectural registers.
    always_comb begin
        gpr_d  = gpr_q;
        cpsr_d = cpsr_q;
        pc_d   = if_pc_in;
        if (wb_rd_write_en) begin
            gpr_d[wb_rd_num] = wb_rd_val;
        end else begin
            gpr_d[wb_rd_num] = gpr_q[wb_rd_num];
        end
        if (wb_cpsr_write_en) begin
            cpsr_d = wb_cpsr_val;
        end else begin
            cpsr_d = cpsr_q;
        end
    end

    // State registers; reset clears everything and discards pending writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
            cpsr_q <= '0;
            pc_q   <= PC_RST;
        end else begin
            gpr_q  <= gpr_d;
            cpsr_q <= cpsr_d;
            pc_q   <= pc_d;
        end
    end

    // Bypass is suppressed under reset so readers see the cleared state at once.
    function automatic logic [DATA_W-1:0] gpr_read(input logic [REG_AW-1:0] num);
        if (!reset && wb_rd_write_en && (num == wb_rd_num)) begin
            return wb_rd_val;
        end else begin
            return gpr_q[num];
        end
    endfunction

    // Execute-stage read ports and debug views of stored state.
    always_comb begin
        exe_rd_data_out = gpr_read(exe_rd_num);
        exe_rs_data_out = gpr_read(exe_rs_num);
        exe_rt_data_out = gpr_read(exe_rt_num);
        if (!reset && wb_cpsr_write_en) begin
            exe_cpsr_out = wb_cpsr_val;
        end else begin
            exe_cpsr_out = cpsr_q;
        end
        if_pc_out   = pc_q;
        wb_rd_out   = gpr_q[wb_rd_num];
        wb_cpsr_out = cpsr_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_num_passthrough;
    logic [31:0] mem_passthrough, result, cpsr_passthrough, dmem_val_passthrough;
    logic        is_alu_op_passthrough, is_cmp_op_passthrough, is_ld_op_passthrough;
    logic [31:0] if_pc_in, if_pc_out;
    logic [3:0]  exe_rd_num, exe_rs_num, exe_rt_num;
    logic [31:0] exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out;
    logic [3:0]  wb_rd_num;
    logic        wb_rd_write_en, wb_cpsr_write_en;
    logic [31:0] wb_rd_val, wb_cpsr_val, wb_rd_out, wb_cpsr_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                   (clk),
        .reset                 (reset),
        .rd_num_passthrough    (rd_num_passthrough),
        .mem_passthrough       (mem_passthrough),
        .result                (result),
        .cpsr_passthrough      (cpsr_passthrough),
        .dmem_val_passthrough  (dmem_val_passthrough),
        .is_alu_op_passthrough (is_alu_op_passthrough),
        .is_cmp_op_passthrough (is_cmp_op_passthrough),
        .is_ld_op_passthrough  (is_ld_op_passthrough),
        .if_pc_in              (if_pc_in),
        .if_pc_out             (if_pc_out),
        .exe_rd_num            (exe_rd_num),
        .exe_rs_num            (exe_rs_num),
        .exe_rt_num            (exe_rt_num),
        .exe_rd_data_out       (exe_rd_data_out),
        .exe_rs_data_out       (exe_rs_data_out),
        .exe_rt_data_out       (exe_rt_data_out),
        .exe_cpsr_out          (exe_cpsr_out),
        .wb_rd_num             (wb_rd_num),
        .wb_rd_write_en        (wb_rd_write_en),
        .wb_rd_val             (wb_rd_val),
        .wb_cpsr_write_en      (wb_cpsr_write_en),
        .wb_cpsr_val           (wb_cpsr_val),
        .wb_rd_out             (wb_rd_out),
        .wb_cpsr_out           (wb_cpsr_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic alu, input logic cmp, input logic ld);
        is_alu_op_passthrough = alu;
        is_cmp_op_passthrough = cmp;
        is_ld_op_passthrough  = ld;
    endtask

    initial begin
        reset = 1'b1;
        rd_num_passthrough = 4'd0;
        mem_passthrough = 32'h0;
        result = 32'h0;
        cpsr_passthrough = 32'h0;
        dmem_val_passthrough = 32'h0;
        set_flags(1'b0, 1'b0, 1'b0);
        if_pc_in = 32'h0;
        exe_rd_num = 4'd0;
        exe_rs_num = 4'd0;
        exe_rt_num = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Dirty some state so the asynchronous reset has something to clear.
        set_flags(1'b1, 1'b1, 1'b0);
        rd_num_passthrough = 4'd3; result = 32'h77; cpsr_passthrough = 32'hF;
        if_pc_in = 32'h40; exe_rs_num = 4'd3; exe_rd_num = 4'd3; exe_rt_num = 4'd3;
        @(posedge clk); #1;
        check("pre_rst_r3", wb_rd_out, 32'h77);
        check("pre_rst_pc", if_pc_out, 32'h40);
        check("pre_rst_cpsr", wb_cpsr_out, 32'hF);

        @(negedge clk);
        result = 32'h99;
        #2 reset = 1'b1;
        #1;
        check("rst_exe_rd", exe_rd_data_out, 32'h0);
        check("rst_exe_rs", exe_rs_data_out, 32'h0);
        check("rst_exe_rt", exe_rt_data_out, 32'h0);
        check("rst_pc", if_pc_out, 32'h0);
        check("rst_exe_cpsr", exe_cpsr_out, 32'h0);
        check("rst_wb_rd_out", wb_rd_out, 32'h0);
        @(posedge clk); #1;
        check("rst_held_r3", wb_rd_out, 32'h0);
        check("rst_held_cpsr", wb_cpsr_out, 32'h0);
        check("rst_held_pc", if_pc_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        if_pc_in = 32'h0;

        // ALU writes to every register, r0 and r15 included.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_flags(1'b1, 1'b0, 1'b0);
            rd_num_passthrough = 4'(i); result = 32'(i);
            #1;
            check("alu_wen", {31'h0, wb_rd_write_en}, 32'h1);
            check("alu_cwen", {31'h0, wb_cpsr_write_en}, 32'h0);
            check("alu_val", wb_rd_val, 32'(i));
            @(posedge clk); #1;
            check("alu_stored", wb_rd_out, 32'(i));
        end
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            exe_rs_num = 4'(k);
            #1 check("alu_read_rs", exe_rs_data_out, 32'(k));
        end

        // CMP writes: CPSR only, GPRs untouched.
        @(negedge clk);
        rd_num_passthrough = 4'd0; result = 32'hFFFF;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            set_flags(1'b0, 1'b1, 1'b0);
            cpsr_passthrough = 32'(v);
            #1;
            check("cmp_rwen", {31'h0, wb_rd_write_en}, 32'h0);
            check("cmp_cwen", {31'h0, wb_cpsr_write_en}, 32'h1);
            check("cmp_bypass", exe_cpsr_out, 32'(v));
            @(posedge clk); #1;
            check("cmp_stored", wb_cpsr_out, 32'(v));
        end
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0);
        exe_rs_num = 4'd0; exe_rt_num = 4'd7;
        #1;
        check("cmp_r0_kept", exe_rs_data_out, 32'h0);
        check("cmp_r7_kept", exe_rt_data_out, 32'h7);

        // Loads: load data beats the ALU result.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_flags(1'b0, 1'b0, 1'b1);
            rd_num_passthrough = 4'(i); result = 32'hDEAD;
            dmem_val_passthrough = 32'(i) + 32'h100;
            @(posedge clk); #1;
            check("ld_stored", wb_rd_out, 32'(i) + 32'h100);
        end
        @(negedge clk);
        set_flags(1'b1, 1'b0, 1'b1);
        rd_num_passthrough = 4'd9; result = 32'hAAAA; dmem_val_passthrough = 32'h5555;
        #1 check("alu_ld_val", wb_rd_val, 32'h5555);
        @(posedge clk); #1;
        check("alu_ld_stored", wb_rd_out, 32'h5555);

        // ALU and CMP commit together.
        @(negedge clk);
        set_flags(1'b1, 1'b1, 1'b0);
        rd_num_passthrough = 4'd2; result = 32'h1234; cpsr_passthrough = 32'h8;
        @(posedge clk); #1;
        check("dual_gpr", wb_rd_out, 32'h1234);
        check("dual_cpsr", wb_cpsr_out, 32'h8);

        // Same-cycle bypass vs. stored debug view.
        @(negedge clk);
        set_flags(1'b1, 1'b0, 1'b0);
        rd_num_passthrough = 4'd5; result = 32'hA5;
        exe_rt_num = 4'd5; exe_rs_num = 4'd6;
        #1;
        check("byp_rt", exe_rt_data_out, 32'hA5);
        check("byp_rs_other", exe_rs_data_out, 32'h106);
        check("byp_old_stored", wb_rd_out, 32'h105);
        check("byp_cpsr_none", exe_cpsr_out, 32'h8);
        @(posedge clk); #1;
        check("byp_new_stored", wb_rd_out, 32'hA5);

        // PC follows if_pc_in one edge later; no flags means no writes.
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0);
        result = 32'hBEEF; cpsr_passthrough = 32'h3;
        for (int p = 1; p <= 3; p++) begin
            @(negedge clk);
            if_pc_in = 32'(4 * p);
            #1 check("pc_before_edge", if_pc_out, 32'(4 * (p - 1)));
            @(posedge clk); #1;
            check("pc_after_edge", if_pc_out, 32'(4 * p));
        end
        check("idle_rwen", {31'h0, wb_rd_write_en}, 32'h0);
        check("idle_cwen", {31'h0, wb_cpsr_write_en}, 32'h0);
        check("idle_r5", wb_rd_out, 32'hA5);
        check("idle_cpsr", wb_cpsr_out, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
